fifo_mc_sync: RTL and testbench
===============================

Name: fifo_mc_sync

Overview:
- Single-clock, multi-channel FIFO: CH = 2**CH_LOG independent logical queues share one distributed-RAM array, each partitioned to 2**DEPTH_LOG words of WIDTH bits.
- Per-channel full/empty/word-count flags.
- First-word-fall-through read data for the channel selected by i_rd_ch.
- Sits between a NoC/crossbar input port and a channel arbiter, replacing per-VC FIFO instances.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH_LOG, 5: log2 of per-channel depth (depth 32); range 1..8.
- CH_LOG, 2: log2 of channel count (4 channels); range 1..4.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronised externally.
- i_wr_data  in  WIDTH  write word.
- i_wr_ch  in  CH_LOG  target channel of the write.
- i_wr_en  in  1  write request.
- o_full  out  CH  per-channel full flag.
- i_rd_ch  in  CH_LOG  channel selected for read/peek.
- i_rd_en  in  1  pop request for i_rd_ch.
- o_rd_data  out  WIDTH  head word of channel i_rd_ch (combinational from RAM and pointer).
- o_empty  out  CH  per-channel empty flag.
- o_words  out  CH*(DEPTH_LOG+1)  per-channel occupancy; channel c occupies bits [c*(DEPTH_LOG+1) +: DEPTH_LOG+1].

Behaviour:
- RAM: CH*2**DEPTH_LOG entries. Physical address = {channel, local pointer}. RAM is not reset.
- Per channel c:
  - wr_ptr[c] and rd_ptr[c]: DEPTH_LOG bits, wrapping naturally modulo depth.
  - cnt[c]: DEPTH_LOG+1 bits.
- Reset (rst_n=0, asynchronous): all pointers 0, all cnt 0, o_empty all 1, o_full all 0, o_words all 0. o_rd_data is X until the first write to the selected channel.
- Write accepted iff i_wr_en & ~o_full[i_wr_ch]. On acceptance:
  - mem[{i_wr_ch, wr_ptr}] <= i_wr_data.
  - wr_ptr increments.
- A write to a full channel is dropped. Pointers, count and RAM are unchanged, even if the same channel is popped in the same cycle.
- Read accepted iff i_rd_en & ~o_empty[i_rd_ch]. On acceptance, rd_ptr increments. A pop of an empty channel is ignored, with no bypass from a same-cycle write.
- o_rd_data = mem[{i_rd_ch, rd_ptr[i_rd_ch]}] at all times. It is valid only while ~o_empty[i_rd_ch]. Changing i_rd_ch changes o_rd_data within the same cycle.
- Write-to-read latency: a word written at edge N clears o_empty at edge N and is visible on o_rd_data after edge N (1 cycle).
- cnt update per channel:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged on both or neither.
- Writes and reads to different channels in the same cycle are fully independent.
- Flags are registered and derived from next-state count:
  - o_empty[c] = (cnt[c]==0).
  - o_full[c] = (cnt[c]==2**DEPTH_LOG).
  - o_words mirrors cnt.
- Wrap-around: after 2**DEPTH_LOG writes, wr_ptr returns to 0. Data ordering is preserved across the wrap.
- Reset mid-operation discards all contents immediately, regardless of in-flight requests.
- Simulation delay on sequential assignments uses the team's `dh macro.

Optional Feature:
- Macro FIFO_MC_ERR_EN.
- Defined: adds output o_err[CH] and input i_err_clr.
  - o_err[c] is a sticky flag. It sets on the edge after a dropped write to full channel c, or after a pop of empty channel c.
  - The flag clears on i_err_clr=1 or reset. Set has priority over clear in the same cycle.
- Undefined: ports are absent, no error logic is built, and dropped requests are silently ignored.

Decomposition:
- Package/include fifo_mc_defs holds:
  - derived constants: DEPTH = 2**DEPTH_LOG, CH = 2**CH_LOG, CNT_W = DEPTH_LOG+1;
  - the physical-address construction helper.
- Sub-module fifo_mc_ch_ctrl: one per channel via generate. It holds wr_ptr, rd_ptr, cnt and the full/empty/err registers, with inputs wr_go/rd_go.
- The top level holds the RAM, the channel decode and the output muxing.

Test Plan:
- Reset then idle: o_empty=4'b1111, o_full=0, all o_words=0. Popping ch2 with i_rd_en=1 leaves everything unchanged; with FIFO_MC_ERR_EN defined, o_err[2]=1.
- Write 0x1111, 0x2222 to ch1: after 2 edges, o_words ch1=2 and o_empty[1]=0. With i_rd_ch=1, o_rd_data=0x1111; after a pop, o_rd_data=0x2222.
- Fill ch0 with 32 words 0x0000..0x001F:
  - o_full[0]=1 after the 32nd edge.
  - A 33rd write 0xDEAD is dropped.
  - Draining returns 0x0000..0x001F in order; o_empty[0]=1 after the 32nd pop.
- Wrap: push/pop ch3 for 100 words with occupancy held at 3. Data ordering is preserved, and o_words ch3 stays 3 throughout the steady state.
- Same cycle: write ch0 and pop ch0 with cnt=5 gives cnt=5. Write ch1 and pop ch2 gives ch1 +1 and ch2 -1. Write plus pop on a full channel: pop accepted, write dropped, cnt=31.
- Assert rst_n=0 mid-burst with ch0=10 and ch1=4 words: o_empty=4'b1111 and o_words=0 asynchronously, before the next edge.

Source files
------------

// File: rtl/fifo_mc_sync_pkg.sv
// Shared definitions for the multi-channel FIFO: derived-size helpers and
// the physical RAM address construction. Also provides a default (empty)
// `DH sequential-assignment delay macro when the build does not supply one.
// Optional feature macro used by the design: FIFO_MC_ERR_EN.
`ifndef DH
`define DH
`endif

package fifo_mc_defs;

  // Widest physical address supported: CH_LOG <= 4, DEPTH_LOG <= 8
  localparam int ADDR_MAX_W = 12;

  function automatic int depth_of(input int depth_log);
    return 1 << depth_log;
  endfunction

  function automatic int ch_of(input int ch_log);
    return 1 << ch_log;
  endfunction

  function automatic int cnt_w_of(input int depth_log);
    return depth_log + 1;
  endfunction

  // Physical address = {channel, local pointer}
  function automatic logic [ADDR_MAX_W-1:0] phys_addr(input logic [3:0] ch,
                                                      input logic [7:0] ptr,
                                                      input int depth_log);
    return (ADDR_MAX_W'(ch) << depth_log) | ADDR_MAX_W'(ptr);
  endfunction

endpackage

// File: rtl/fifo_mc_sync_ch_ctrl.sv
// Per-channel FIFO bookkeeping: pointers, occupancy and registered flags.
// Flags are registered from the next-state count so they line up with cnt.
// With FIFO_MC_ERR_EN defined, also keeps a sticky overflow/underflow flag.
module fifo_mc_ch_ctrl
  import fifo_mc_defs::*;
#(
  parameter int DEPTH_LOG = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_go,
  input  logic                 rd_go,
`ifdef FIFO_MC_ERR_EN
  input  logic                 err_clr,
  output logic                 err,
`endif
  output logic                 wr_acc,
  output logic [DEPTH_LOG-1:0] wr_ptr,
  output logic [DEPTH_LOG-1:0] rd_ptr,
  output logic [DEPTH_LOG:0]   cnt,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = depth_of(DEPTH_LOG);
  localparam int CNT_W = cnt_w_of(DEPTH_LOG);

  logic             rd_acc;
  logic [CNT_W-1:0] cnt_nxt;

  // A full channel drops writes even if it is popped in the same cycle
  assign wr_acc = wr_go & ~full;
  assign rd_acc = rd_go & ~empty;

  // Next occupancy: simultaneous push and pop cancel out
  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)
      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = cnt - 1'b1;
  end

  // Pointer, count and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= `DH '0;
      rd_ptr <= `DH '0;
      cnt    <= `DH '0;
      full   <= `DH 1'b0;
      empty  <= `DH 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= `DH wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= `DH rd_ptr + 1'b1;
      cnt   <= `DH cnt_nxt;
      full  <= `DH (cnt_nxt == CNT_W'(DEPTH));
      empty <= `DH (cnt_nxt == '0);
    end
  end

`ifdef FIFO_MC_ERR_EN
  // Sticky error on dropped write or ignored pop; set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= `DH 1'b0;
    else if ((wr_go && full) || (rd_go && empty))
      err <= `DH 1'b1;
    else if (err_clr)
      err <= `DH 1'b0;
  end
`endif

endmodule

// File: rtl/fifo_mc_sync.sv
// Single-clock multi-channel FIFO: 2**CH_LOG logical queues share one RAM,
// each owning a 2**DEPTH_LOG-word slice. Read data is first-word-fall-through
// for the channel on i_rd_ch. Optional macro FIFO_MC_ERR_EN adds sticky
// per-channel error flags (o_err) with a clear input (i_err_clr).
module fifo_mc_sync
  import fifo_mc_defs::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH_LOG = 5,
  parameter int CH_LOG    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [WIDTH-1:0]                       i_wr_data,
  input  logic [CH_LOG-1:0]                      i_wr_ch,
  input  logic                                   i_wr_en,
  output logic [(2**CH_LOG)-1:0]                 o_full,
  input  logic [CH_LOG-1:0]                      i_rd_ch,
  input  logic                                   i_rd_en,
  output logic [WIDTH-1:0]                       o_rd_data,
  output logic [(2**CH_LOG)-1:0]                 o_empty,
`ifdef FIFO_MC_ERR_EN
  output logic [(2**CH_LOG)-1:0]                 o_err,
  input  logic                                   i_err_clr,
`endif
  output logic [(2**CH_LOG)*(DEPTH_LOG+1)-1:0]   o_words
);

  localparam int CH       = ch_of(CH_LOG);
  localparam int DEPTH    = depth_of(DEPTH_LOG);
  localparam int CNT_W    = cnt_w_of(DEPTH_LOG);
  localparam int ADDR_W   = CH_LOG + DEPTH_LOG;
  localparam int RAM_SIZE = CH * DEPTH;

  logic [WIDTH-1:0]     mem [RAM_SIZE];
  logic [DEPTH_LOG-1:0] wr_ptr [CH];
  logic [DEPTH_LOG-1:0] rd_ptr [CH];
  logic [CNT_W-1:0]     cnt    [CH];
  logic [CH-1:0]        wr_acc;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    fifo_mc_ch_ctrl #(
      .DEPTH_LOG (DEPTH_LOG)
    ) u_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_go   (i_wr_en && (i_wr_ch == CH_LOG'(c))),
      .rd_go   (i_rd_en && (i_rd_ch == CH_LOG'(c))),
`ifdef FIFO_MC_ERR_EN
      .err_clr (i_err_clr),
      .err     (o_err[c]),
`endif
      .wr_acc  (wr_acc[c]),
      .wr_ptr  (wr_ptr[c]),
      .rd_ptr  (rd_ptr[c]),
      .cnt     (cnt[c]),
      .full    (o_full[c]),
      .empty   (o_empty[c])
    );

    assign o_words[c*CNT_W +: CNT_W] = cnt[c];
  end

  assign wr_addr = ADDR_W'(phys_addr(4'(i_wr_ch), 8'(wr_ptr[i_wr_ch]), DEPTH_LOG));
  assign rd_addr = ADDR_W'(phys_addr(4'(i_rd_ch), 8'(rd_ptr[i_rd_ch]), DEPTH_LOG));

  // Shared storage; contents are not reset
  always_ff @(posedge clk) begin
    if (|wr_acc)
      mem[wr_addr] <= `DH i_wr_data;
  end

  assign o_rd_data = mem[rd_addr];

endmodule

// File: tb/tb_fifo_mc_sync.sv
// Directed self-checking bench for fifo_mc_sync (WIDTH=16, DEPTH_LOG=5, CH_LOG=2).
module tb_fifo_mc_sync;

  localparam int WIDTH = 16;
  localparam int DLOG  = 5;
  localparam int CLOG  = 2;
  localparam int CW    = DLOG + 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] i_wr_data;
  logic [CLOG-1:0]  i_wr_ch;
  logic             i_wr_en;
  logic [3:0]       o_full;
  logic [CLOG-1:0]  i_rd_ch;
  logic             i_rd_en;
  logic [WIDTH-1:0] o_rd_data;
  logic [3:0]       o_empty;
  logic [4*CW-1:0]  o_words;
`ifdef FIFO_MC_ERR_EN
  logic [3:0]       o_err;
  logic             i_err_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_mc_sync #(.WIDTH(WIDTH), .DEPTH_LOG(DLOG), .CH_LOG(CLOG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_data (i_wr_data),
    .i_wr_ch   (i_wr_ch),
    .i_wr_en   (i_wr_en),
    .o_full    (o_full),
    .i_rd_ch   (i_rd_ch),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_empty   (o_empty),
`ifdef FIFO_MC_ERR_EN
    .o_err     (o_err),
    .i_err_clr (i_err_clr),
`endif
    .o_words   (o_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] words_of(input int c);
    return o_words[c*CW +: CW];
  endfunction

  // One clock of stimulus: drive at negedge, sample 1 ns after posedge
  task automatic do_op(input logic we, input int wch, input logic [WIDTH-1:0] wd,
                       input logic re, input int rch);
    @(negedge clk);
    i_wr_en   = we;
    i_wr_ch   = CLOG'(wch);
    i_wr_data = wd;
    i_rd_en   = re;
    i_rd_ch   = CLOG'(rch);
    @(posedge clk);
    #1;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (o_empty !== 4'b1111) begin n_fail++; $display("FAIL reset_empty got %b want 1111", o_empty); end
    n_checks++;
    if (o_full !== 4'b0000) begin n_fail++; $display("FAIL reset_full got %b want 0000", o_full); end
    n_checks++;
    if (o_words !== '0) begin n_fail++; $display("FAIL reset_words got %h want 0", o_words); end
    do_op(1'b0, 0, 16'h0, 1'b1, 2);
    n_checks++;
    if (o_empty !== 4'b1111 || o_words !== '0 || o_full !== 4'b0000) begin
      n_fail++; $display("FAIL pop_empty_ch2 empty=%b words=%h full=%b want 1111/0/0", o_empty, o_words, o_full);
    end
`ifdef FIFO_MC_ERR_EN
    n_checks++;
    if (o_err !== 4'b0100) begin n_fail++; $display("FAIL err_pop_empty got %b want 0100", o_err); end
    @(negedge clk); i_err_clr = 1'b1;
    @(posedge clk); #1; i_err_clr = 1'b0;
    n_checks++;
    if (o_err !== 4'b0000) begin n_fail++; $display("FAIL err_clear got %b want 0000", o_err); end
`endif
  endtask

  task automatic test_two_words();
    do_op(1'b1, 1, 16'h1111, 1'b0, 1);
    do_op(1'b1, 1, 16'h2222, 1'b0, 1);
    n_checks++;
    if (words_of(1) !== 6'd2) begin n_fail++; $display("FAIL ch1_words got %0d want 2", words_of(1)); end
    n_checks++;
    if (o_empty[1] !== 1'b0) begin n_fail++; $display("FAIL ch1_empty got %b want 0", o_empty[1]); end
    n_checks++;
    if (o_rd_data !== 16'h1111) begin n_fail++; $display("FAIL ch1_head0 got %h want 1111", o_rd_data); end
    do_op(1'b0, 0, 16'h0, 1'b1, 1);
    n_checks++;
    if (o_rd_data !== 16'h2222) begin n_fail++; $display("FAIL ch1_head1 got %h want 2222", o_rd_data); end
    do_op(1'b0, 0, 16'h0, 1'b1, 1);
    n_checks++;
    if (o_empty[1] !== 1'b1 || words_of(1) !== 6'd0) begin
      n_fail++; $display("FAIL ch1_drained empty=%b words=%0d want 1/0", o_empty[1], words_of(1));
    end
  endtask

  task automatic test_fill_ch0();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (o_full[0] !== 1'b0) begin n_fail++; $display("FAIL ch0_full_early at %0d got 1 want 0", i); end
      do_op(1'b1, 0, 16'(i), 1'b0, 0);
    end
    n_checks++;
    if (o_full[0] !== 1'b1 || words_of(0) !== 6'd32) begin
      n_fail++; $display("FAIL ch0_full full=%b words=%0d want 1/32", o_full[0], words_of(0));
    end
    do_op(1'b1, 0, 16'hDEAD, 1'b0, 0);
    n_checks++;
    if (words_of(0) !== 6'd32 || o_rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL ch0_overflow words=%0d head=%h want 32/0000", words_of(0), o_rd_data);
    end
`ifdef FIFO_MC_ERR_EN
    n_checks++;
    if (o_err[0] !== 1'b1) begin n_fail++; $display("FAIL err_overflow got %b want 1", o_err[0]); end
`endif
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (o_rd_data !== 16'(i)) begin n_fail++; $display("FAIL ch0_drain[%0d] got %h want %h", i, o_rd_data, 16'(i)); end
      do_op(1'b0, 0, 16'h0, 1'b1, 0);
    end
    n_checks++;
    if (o_empty[0] !== 1'b1 || o_full[0] !== 1'b0) begin
      n_fail++; $display("FAIL ch0_empty_after empty=%b full=%b want 1/0", o_empty[0], o_full[0]);
    end
  endtask

  task automatic test_wrap();
    int rd_idx;
    rd_idx = 0;
    for (int i = 0; i < 3; i++) do_op(1'b1, 3, 16'h0300 + 16'(i), 1'b0, 3);
    for (int i = 3; i < 100; i++) begin
      n_checks++;
      if (o_rd_data !== 16'h0300 + 16'(rd_idx)) begin
        n_fail++; $display("FAIL wrap_head[%0d] got %h want %h", rd_idx, o_rd_data, 16'h0300 + 16'(rd_idx));
      end
      do_op(1'b1, 3, 16'h0300 + 16'(i), 1'b1, 3);
      rd_idx++;
      n_checks++;
      if (words_of(3) !== 6'd3) begin n_fail++; $display("FAIL wrap_words[%0d] got %0d want 3", i, words_of(3)); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_rd_data !== 16'h0300 + 16'(rd_idx)) begin
        n_fail++; $display("FAIL wrap_tail[%0d] got %h want %h", rd_idx, o_rd_data, 16'h0300 + 16'(rd_idx));
      end
      do_op(1'b0, 0, 16'h0, 1'b1, 3);
      rd_idx++;
    end
    n_checks++;
    if (o_empty[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", o_empty[3]); end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 5; i++) do_op(1'b1, 0, 16'h0500 + 16'(i), 1'b0, 0);
    do_op(1'b1, 0, 16'h0505, 1'b1, 0);
    n_checks++;
    if (words_of(0) !== 6'd5 || o_rd_data !== 16'h0501) begin
      n_fail++; $display("FAIL same_ch words=%0d head=%h want 5/0501", words_of(0), o_rd_data);
    end
    do_op(1'b1, 2, 16'h02A0, 1'b0, 2);
    do_op(1'b1, 1, 16'h01B0, 1'b1, 2);
    n_checks++;
    if (words_of(1) !== 6'd1 || words_of(2) !== 6'd0 || o_empty[2] !== 1'b1) begin
      n_fail++; $display("FAIL diff_ch w1=%0d w2=%0d e2=%b want 1/0/1", words_of(1), words_of(2), o_empty[2]);
    end
    for (int i = 0; i < 27; i++) do_op(1'b1, 0, 16'h0600 + 16'(i), 1'b0, 0);
    n_checks++;
    if (o_full[0] !== 1'b1) begin n_fail++; $display("FAIL refill_full got %b want 1", o_full[0]); end
    do_op(1'b1, 0, 16'hBEEF, 1'b1, 0);
    n_checks++;
    if (words_of(0) !== 6'd31 || o_full[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_wr_rd words=%0d full=%b want 31/0", words_of(0), o_full[0]);
    end
    for (int i = 0; i < 31; i++) begin
      logic [WIDTH-1:0] exp;
      exp = (i < 4) ? 16'h0502 + 16'(i) : 16'h0600 + 16'(i - 4);
      n_checks++;
      if (o_rd_data !== exp) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", i, o_rd_data, exp); end
      do_op(1'b0, 0, 16'h0, 1'b1, 0);
    end
    n_checks++;
    if (o_empty[0] !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty got %b want 1", o_empty[0]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 10; i++) do_op(1'b1, 0, 16'h0A00 + 16'(i), 1'b0, 0);
    for (int i = 0; i < 4; i++) do_op(1'b1, 1, 16'h0B00 + 16'(i), 1'b0, 0);
    n_checks++;
    if (words_of(0) !== 6'd10 || words_of(1) !== 6'd4) begin
      n_fail++; $display("FAIL pre_reset w0=%0d w1=%0d want 10/4", words_of(0), words_of(1));
    end
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_ch = 2'd0; i_wr_data = 16'h0CCC;
    i_rd_en = 1'b1; i_rd_ch = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_empty !== 4'b1111 || o_words !== '0 || o_full !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset empty=%b words=%h full=%b want 1111/0/0", o_empty, o_words, o_full);
    end
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_empty !== 4'b1111 || o_words !== '0) begin
      n_fail++; $display("FAIL post_reset empty=%b words=%h want 1111/0", o_empty, o_words);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    i_wr_data = '0;
    i_wr_ch   = '0;
    i_wr_en   = 1'b0;
    i_rd_ch   = '0;
    i_rd_en   = 1'b0;
`ifdef FIFO_MC_ERR_EN
    i_err_clr = 1'b0;
`endif
    test_reset();
    test_two_words();
    test_fill_ch0();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
